// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: write-through D-cache controller FSM with internal memory wait counter; define WRITE_ALLOCATE_EN for write-allocate on write miss
module cache_ctrl_fsm #(
  parameter int MEM_WAIT = 4,
  parameter int CTR_W = $clog2(MEM_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic rw,
  input  logic m,
  input  logic v,
  output logic rdy,
  output logic busy,
  output logic w,
  output logic wsel,
  output logic rsel,
  output logic mstrobe,
  output logic mrw
);
  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] READ       = 4'd1;
  localparam logic [3:0] READ_MISS  = 4'd2;
  localparam logic [3:0] READ_MEM   = 4'd3;
  localparam logic [3:0] READ_DATA  = 4'd4;
  localparam logic [3:0] WRITE      = 4'd5;
  localparam logic [3:0] WRITE_HIT  = 4'd6;
  localparam logic [3:0] WRITE_MISS = 4'd7;
  localparam logic [3:0] WRITE_MEM  = 4'd8;
  localparam logic [3:0] WRITE_DATA = 4'd9;
  localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(MEM_WAIT - 1);
`ifdef WRITE_ALLOCATE_EN
  localparam logic ALLOC = 1'b1;
`else
  localparam logic ALLOC = 1'b0;
`endif
  logic [3:0] state, state_nx;
  logic [CTR_W-1:0] cnt, cnt_nx, cnt_dec;
  logic hit, cnt_zero;
  assign hit = m & v;
  assign cnt_zero = cnt == '0;
  assign cnt_dec = cnt_zero ? cnt : cnt - CTR_W'(1);
  // next state and wait counter: counter loads on entry to a memory state and counts down to zero there
  always_comb begin
    state_nx = IDLE;
    cnt_nx = cnt;
    case (state)
      IDLE: state_nx = strobe ? (rw ? WRITE : READ) : IDLE;
      READ: begin
        state_nx = hit ? READ_DATA : READ_MISS;
        cnt_nx = hit ? cnt : CTR_LOAD;
      end
      READ_MISS: begin
        state_nx = cnt_zero ? READ_MEM : READ_MISS;
        cnt_nx = cnt_dec;
      end
      READ_MEM: state_nx = READ_DATA;
      READ_DATA: state_nx = IDLE;
      WRITE: state_nx = hit ? WRITE_HIT : WRITE_MISS;
      WRITE_HIT, WRITE_MISS: begin
        state_nx = WRITE_MEM;
        cnt_nx = CTR_LOAD;
      end
      WRITE_MEM: begin
        state_nx = cnt_zero ? WRITE_DATA : WRITE_MEM;
        cnt_nx = cnt_dec;
      end
      WRITE_DATA: state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  // state register; reset abandons any memory access immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  assign busy = (state != IDLE) && (state <= WRITE_DATA);
  assign rdy = (state == READ_DATA) || (state == WRITE_DATA);
  assign w = (state == READ_MEM) || (state == WRITE_HIT) || (ALLOC && state == WRITE_MISS);
  assign wsel = state == READ_MEM;
  assign rsel = (state == READ_MISS) || (state == READ_MEM);
  assign mstrobe = (state == READ_MISS) || (state == WRITE_MEM);
  assign mrw = state == WRITE_MEM;
endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Parametrised controller FSM for the direct-mapped, write-through data cache. It sits between the CPU request interface (strobe/rw) and the main-memory interface (mstrobe/mrw). It sequences read hit, read miss with line fill, and write-through hit and miss. It replaces the external wait counter (LdCtr/CtrSig) with an internal counter sized by parameter.

Parameters:
MEM_WAIT, 4, main-memory access length in cycles (>=1); mstrobe held for exactly this many cycles per access
CTR_W, $clog2(MEM_WAIT+1), width of internal wait counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
strobe  in  1  CPU request valid; sampled only in IDLE
rw  in  1  request type, 1 = write, 0 = read; captured with strobe
m  in  1  tag match from tag compare; sampled only in READ/WRITE
v  in  1  valid bit of indexed line; sampled only in READ/WRITE
rdy  out  1  one-cycle completion pulse to CPU
busy  out  1  high in every state except IDLE
w  out  1  cache data/tag/valid write enable
wsel  out  1  cache write-data select: 0 = CPU data, 1 = memory data
rsel  out  1  CPU read-data select: 0 = cache array, 1 = memory bus
mstrobe  out  1  memory access request
mrw  out  1  memory access type, 1 = write, 0 = read

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all outputs 0 immediately; an in-flight memory access is abandoned (mstrobe drops without waiting).
- Outputs are Moore (decoded from state); default 0 unless listed.
- Hit = m & v.
- IDLE: strobe=1 -> READ if rw=0, WRITE if rw=1; otherwise stay.
- READ (1 cycle): hit -> READ_DATA; miss -> READ_MISS, counter loaded MEM_WAIT-1.
- READ_MISS: mstrobe=1, mrw=0, rsel=1. Counter decrements each cycle. At counter==0 -> READ_MEM. Lasts exactly MEM_WAIT cycles.
- READ_MEM (1 cycle): w=1, wsel=1, rsel=1 (fill line from memory bus, set valid) -> READ_DATA.
- READ_DATA (1 cycle): rdy=1, rsel=0 -> IDLE.
- WRITE (1 cycle): hit -> WRITE_HIT; miss -> WRITE_MISS.
- WRITE_HIT (1 cycle): w=1, wsel=0 -> WRITE_MEM, counter loaded MEM_WAIT-1.
- WRITE_MISS (1 cycle): no cache write (no-allocate; see Optional Feature) -> WRITE_MEM, counter loaded MEM_WAIT-1.
- WRITE_MEM: mstrobe=1, mrw=1; decrement; at counter==0 -> WRITE_DATA. Lasts MEM_WAIT cycles.
- WRITE_DATA (1 cycle): rdy=1 -> IDLE.
- busy=1 in all non-IDLE states.
- Latency from the accepting edge (cycle 0): read hit rdy at cycle 2; read miss at cycle MEM_WAIT+3; write hit/miss at cycle MEM_WAIT+3.
- strobe while busy is ignored (not queued); CPU must hold the request until rdy.
- Back-to-back: strobe=1 in the cycle after rdy is accepted (IDLE reached).
- MEM_WAIT=1: the counter loads 0, so the memory state lasts one cycle. The counter never wraps; it only loads or decrements while nonzero.
- Unused state encodings go to IDLE with outputs 0.
- m/v are ignored outside READ/WRITE.

Optional Feature:
WRITE_ALLOCATE_EN. Defined: WRITE_MISS asserts w=1, wsel=0 (line written with CPU data, tag updated, valid set). Timing is unchanged, so a subsequent read of that address hits. Undefined: WRITE_MISS asserts no outputs (write-through, no-allocate), and a later read of that address misses.

Test Plan:
- Reset mid-READ_MISS (MEM_WAIT=4, reset at 2nd mstrobe cycle) -> mstrobe/busy/rsel go 0 asynchronously; after release, state IDLE, strobe accepted next edge.
- Read hit: strobe=1, rw=0 at cycle 0; m=1, v=1 in cycle 1 -> rdy=1 only at cycle 2; mstrobe never asserted; busy high cycles 1-2.
- Read miss, MEM_WAIT=4: m=1, v=0 -> mstrobe=1, mrw=0 cycles 2-5; w=1, wsel=1 cycle 6; rdy cycle 7; exactly one w pulse.
- Write hit, MEM_WAIT=4: rw=1, m=1, v=1 -> w=1, wsel=0 cycle 2; mstrobe=1, mrw=1 cycles 3-6; rdy cycle 7.
- Write miss, MEM_WAIT=4: with WRITE_ALLOCATE_EN, w=1 at cycle 2; without it, w=0 throughout; both give rdy at cycle 7.
- MEM_WAIT=1, back-to-back read miss then write, with strobe held high continuously -> mstrobe 1 cycle each; read rdy at cycle 4; write accepted cycle 5; write rdy at cycle 9; strobe during busy produces no extra transaction.
